shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Controller that performs multi-bit shifts and rotates using the existing single-step 16-bit shift register (mShiftReg).
- mShiftReg is registered (iD to oQ, one clock) and moves exactly one bit position per clock.
- This block issues one single-bit command per cycle, recirculates the register output back to its input N times, then captures the final value.
- It sits between the ALU operation decoder and mShiftReg and presents a start/busy/done handshake upstream.

Parameters:
DATA_W, 16, datapath width; must match mShiftReg (fixed at 16).
AMT_W, 5, width of the shift amount; legal amounts are 0 to 2^AMT_W-1.

Ports:
iClock  input  1  system clock; all state updates on the rising edge.
iReset  input  1  asynchronous, active-high reset.
iStart  input  1  request pulse; sampled only in IDLE.
iOp  input  2  operation: 00 SRL, 01 SLL, 10 ROR, 11 ROL.
iOperand  input  DATA_W  value to shift; sampled with iStart.
iAmount  input  AMT_W  number of bit positions; sampled with iStart.
iRegQ  input  DATA_W  oQ of mShiftReg.
oRegD  output  DATA_W  drives iD of mShiftReg.
oRegCommand  output  3  drives RegCommand of mShiftReg.
oBusy  output  1  high while an operation is in progress.
oDone  output  1  one-cycle pulse when oResult is updated.
oResult  output  DATA_W  final shifted value; holds until the next completion.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state IDLE, counter 0, first-flag 0.
  - oDone 0, oResult 16'h0000, oBusy 0, oRegCommand 3'b100.
  - An in-flight operation is discarded with no oDone.
- States: IDLE, SHIFT, CAPTURE. oBusy = (state != IDLE), decoded combinationally from the state register.
- Command map in SHIFT: {1'b0, op_reg}, i.e. SRL 000, SLL 001, ROR 010, ROL 011. In IDLE and CAPTURE, oRegCommand = 3'b100 (plain load, no shift).
- oRegD: equals operand_reg in the first SHIFT cycle, otherwise iRegQ (combinational mux on first-flag).
- IDLE, iStart=1 and iAmount=0:
  - oResult <= iOperand; oDone pulses the next cycle.
  - State stays IDLE; oBusy never rises.
- IDLE, iStart=1 and iAmount>0:
  - operand_reg <= iOperand, op_reg <= iOp, cnt <= iAmount, first <= 1.
  - state -> SHIFT.
- SHIFT:
  - first <= 0; cnt <= cnt-1.
  - If cnt==1, state -> CAPTURE; otherwise remain in SHIFT.
  - Exactly iAmount SHIFT cycles occur.
- CAPTURE:
  - oResult <= iRegQ (the output of the final shift); oDone <= 1.
  - state -> IDLE.
- oDone is registered, high for exactly one cycle, otherwise 0.
- Timing, with iStart accepted at cycle 0 and amount N>0:
  - SHIFT during cycles 1..N, CAPTURE at cycle N+1.
  - oDone and the new oResult are visible at cycle N+2.
  - oBusy is high during cycles 1..N+1.
- Timing for N=0: oDone and oResult are visible at cycle 1.
- iStart while busy is ignored; no queuing. iOp, iOperand and iAmount are don't-care outside the iStart cycle.
- Back-to-back: iStart is accepted in the same cycle oDone is high (state is IDLE).
- Amounts of DATA_W or more simply run the full count:
  - SRL/SLL by 16 or more gives 0.
  - Rotate by 16 returns the operand.
- cnt is AMT_W bits wide and never wraps, because the decrement stops at 1.

Test Plan:
- Each scenario uses the bench instance of mShiftReg wired to oRegD/oRegCommand/iRegQ.
- SLL: iOperand 16'h0001, iAmount 4, iStart at cycle 0 -> oBusy high cycles 1-5; oDone at cycle 6 with oResult 16'h0010; oRegCommand 001 during cycles 1-4.
- ROR and ROL:
  - ROR 16'h0001 by 1 -> oResult 16'h8000 at cycle 3.
  - ROL 16'h8001 by 3 -> oResult 16'h000C at cycle 5.
- SRL 16'hFFFF by 16 -> 16 SHIFT cycles, oResult 16'h0000 at cycle 18. Then ROL 16'h1234 by 16 -> 16'h1234.
- iAmount 0 with iOperand 16'hA5A5 -> oDone at cycle 1, oResult 16'hA5A5, oBusy never high, oRegCommand stays 100.
- Handshake:
  - Second iStart (SLL 16'h00FF by 2) asserted mid-operation is ignored; the first result is unaffected.
  - iStart asserted in the oDone cycle is accepted and completes correctly.
- Assert iReset during the third SHIFT cycle of SLL 16'h0001 by 8:
  - Immediately: oBusy 0, oResult 0, oRegCommand 100.
  - No oDone pulse follows.
  - The next request completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a single-step 16-bit shift register (mShiftReg) for
// multi-bit shifts and rotates. The register output is fed back to its input
// once per cycle for the requested number of steps, then the final value is
// captured. A start/busy/done handshake is presented upstream.
module shift_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AMT_W  = 5
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [1:0]        iOp,
    input  logic [DATA_W-1:0] iOperand,
    input  logic [AMT_W-1:0]  iAmount,
    input  logic [DATA_W-1:0] iRegQ,
    output logic [DATA_W-1:0] oRegD,
    output logic [2:0]        oRegCommand,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oResult
);

    // Plain load command for mShiftReg; the shift commands are {1'b0, op}.
    localparam logic [2:0] CmdLoad = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] operandReg;
    logic [1:0]        opReg;
    logic [AMT_W-1:0]  cnt;
    logic              first;

    // State register.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus the combinational interface to mShiftReg.
    always_comb begin
        stateNext   = state;
        oBusy       = 1'b0;
        oRegCommand = CmdLoad;
        oRegD       = first ? operandReg : iRegQ;
        case (state)
            IDLE: begin
                if (iStart && (iAmount != '0)) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                oBusy       = 1'b1;
                oRegCommand = {1'b0, opReg};
                if (cnt == AMT_W'(1)) begin
                    stateNext = CAPTURE;
                end
            end
            CAPTURE: begin
                oBusy     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request capture, step counting and result/done registers.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            operandReg <= '0;
            opReg      <= 2'b00;
            cnt        <= '0;
            first      <= 1'b0;
            oDone      <= 1'b0;
            oResult    <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (iAmount == '0) begin
                            // Zero amount completes immediately without using the register.
                            oResult <= iOperand;
                            oDone   <= 1'b1;
                        end else begin
                            operandReg <= iOperand;
                            opReg      <= iOp;
                            cnt        <= iAmount;
                            first      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    first <= 1'b0;
                    cnt   <= cnt - AMT_W'(1);
                end
                CAPTURE: begin
                    oResult <= iRegQ;
                    oDone   <= 1'b1;
                end
                default: begin
                    first <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural mShiftReg and a
// cycle-level reference model of the handshake and results.
module tb_shift_sequencer;

    logic        iClock;
    logic        iReset;
    logic        iStart;
    logic [1:0]  iOp;
    logic [15:0] iOperand;
    logic [4:0]  iAmount;
    logic [15:0] iRegQ;
    logic [15:0] oRegD;
    logic [2:0]  oRegCommand;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oResult;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int startCyc = 0;

    shift_sequencer #(.DATA_W(16), .AMT_W(5)) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iOp         (iOp),
        .iOperand    (iOperand),
        .iAmount     (iAmount),
        .iRegQ       (iRegQ),
        .oRegD       (oRegD),
        .oRegCommand (oRegCommand),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oResult     (oResult)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    always @(posedge iClock) cyc <= cyc + 1;

    // Behavioural single-step shift register: 000 SRL, 001 SLL, 010 ROR, 011 ROL, 1xx load.
    initial iRegQ = 16'h0000;
    always @(posedge iClock) begin
        case (oRegCommand)
            3'b000:  iRegQ <= oRegD >> 1;
            3'b001:  iRegQ <= oRegD << 1;
            3'b010:  iRegQ <= {oRegD[0], oRegD[15:1]};
            3'b011:  iRegQ <= {oRegD[14:0], oRegD[15]};
            default: iRegQ <= oRegD;
        endcase
    end

    // Reference result from plain arithmetic.
    function automatic logic [15:0] refResult(input logic [1:0] op, input logic [15:0] x, input int amt);
        logic [31:0] dbl;
        int r;
        dbl = {x, x};
        r = amt % 16;
        case (op)
            2'b00:   refResult = (amt >= 16) ? 16'h0000 : (x >> amt);
            2'b01:   refResult = (amt >= 16) ? 16'h0000 : (x << amt);
            2'b10:   begin dbl = dbl >> r; refResult = dbl[15:0]; end
            default: begin dbl = dbl << r; refResult = dbl[31:16]; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: cycle windows of the current operation.
    int          busyFrom = -10;
    int          busyTo   = -11;
    int          cmdTo    = -11;
    logic [1:0]  mOp      = 2'b00;
    logic [15:0] mOperand = 16'h0000;
    logic        pendValid = 1'b0;
    int          pendAt   = 0;
    logic [15:0] pendVal  = 16'h0000;
    logic [15:0] resNow   = 16'h0000;

    // Per-cycle compare against the model, then model acceptance of a request.
    always @(negedge iClock) begin
        logic expDone;
        logic expBusy;
        logic [2:0] expCmd;
        int n;
        if (iReset) begin
            busyFrom  = -10;
            busyTo    = -11;
            cmdTo     = -11;
            pendValid = 1'b0;
            resNow    = 16'h0000;
            check("rst_busy", 32'(oBusy), 32'(0));
            check("rst_done", 32'(oDone), 32'(0));
            check("rst_result", 32'(oResult), 32'(0));
            check("rst_cmd", 32'(oRegCommand), 32'(3'b100));
        end else begin
            expDone = 1'b0;
            if (pendValid && cyc == pendAt) begin
                resNow    = pendVal;
                expDone   = 1'b1;
                pendValid = 1'b0;
            end
            expBusy = (cyc >= busyFrom) && (cyc <= busyTo);
            expCmd  = ((cyc >= busyFrom) && (cyc <= cmdTo)) ? {1'b0, mOp} : 3'b100;
            check("done", 32'(oDone), 32'(expDone));
            check("result", 32'(oResult), 32'(resNow));
            check("busy", 32'(oBusy), 32'(expBusy));
            check("cmd", 32'(oRegCommand), 32'(expCmd));
            if (cyc == busyFrom) check("regd_first", 32'(oRegD), 32'(mOperand));
            else if (cyc > busyFrom && cyc <= cmdTo) check("regd_feedback", 32'(oRegD), 32'(iRegQ));
            if (iStart && !expBusy) begin
                n = int'(iAmount);
                pendVal   = refResult(iOp, iOperand, n);
                pendValid = 1'b1;
                mOp       = iOp;
                mOperand  = iOperand;
                if (n == 0) begin
                    pendAt = cyc + 1;
                end else begin
                    busyFrom = cyc + 1;
                    busyTo   = cyc + n + 1;
                    cmdTo    = cyc + n;
                    pendAt   = cyc + n + 2;
                end
            end
        end
    end

    // Drive one request for one cycle; inputs are randomised afterwards.
    task automatic issue(input logic [1:0] op, input logic [15:0] opd, input logic [4:0] amt);
        @(posedge iClock);
        #1;
        iStart   = 1'b1;
        iOp      = op;
        iOperand = opd;
        iAmount  = amt;
        startCyc = cyc;
        @(posedge iClock);
        #1;
        iStart   = 1'b0;
        iOp      = 2'($urandom);
        iOperand = 16'($urandom);
        iAmount  = 5'($urandom);
    endtask

    // Wait (bounded) for oDone and check latency and result literally.
    task automatic expectDone(input string name, input logic [15:0] exp, input int lat, input int sc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge iClock);
            if (oDone) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check({name, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check({name, "_latency"}, 32'(cyc - sc), 32'(lat));
            check({name, "_value"}, 32'(oResult), 32'(exp));
        end
    endtask

    initial begin
        int sc;
        logic [1:0]  rop;
        logic [15:0] ropd;
        logic [4:0]  ramt;
        iReset = 1'b1;
        iStart = 1'b0;
        iOp = 2'b00;
        iOperand = 16'h0000;
        iAmount = 5'd0;
        repeat (3) @(posedge iClock);
        #1;
        iReset = 1'b0;

        // Directed cases with hand-computed expectations.
        issue(2'b01, 16'h0001, 5'd4);
        expectDone("sll_1x4", 16'h0010, 6, startCyc);
        issue(2'b10, 16'h0001, 5'd1);
        expectDone("ror_1x1", 16'h8000, 3, startCyc);
        issue(2'b11, 16'h8001, 5'd3);
        expectDone("rol_8001x3", 16'h000C, 5, startCyc);
        issue(2'b00, 16'hFFFF, 5'd16);
        expectDone("srl_ffffx16", 16'h0000, 18, startCyc);
        issue(2'b11, 16'h1234, 5'd16);
        expectDone("rol_1234x16", 16'h1234, 18, startCyc);
        issue(2'b00, 16'hA5A5, 5'd0);
        expectDone("zero_amt", 16'hA5A5, 1, startCyc);

        // A request while busy is ignored.
        issue(2'b01, 16'h0003, 5'd5);
        sc = startCyc;
        issue(2'b01, 16'h00FF, 5'd2);
        expectDone("ignored_start", 16'h0060, 7, sc);
        repeat (6) @(posedge iClock);

        // Back-to-back: the next request lands in the oDone cycle.
        issue(2'b10, 16'h00F0, 5'd4);
        repeat (5) @(posedge iClock);
        #1;
        check("b2b_done_cycle", 32'(oDone), 32'(1));
        iStart = 1'b1; iOp = 2'b01; iOperand = 16'h0101; iAmount = 5'd3;
        sc = cyc;
        @(posedge iClock);
        #1;
        iStart = 1'b0;
        expectDone("b2b_second", 16'h0808, 5, sc);

        // Reset during the third SHIFT cycle.
        issue(2'b01, 16'h0001, 5'd8);
        @(posedge iClock);
        #1;
        @(posedge iClock);
        #1;
        iReset = 1'b1;
        #1;
        check("midrst_busy", 32'(oBusy), 32'(0));
        check("midrst_result", 32'(oResult), 32'(0));
        check("midrst_cmd", 32'(oRegCommand), 32'(3'b100));
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        repeat (12) @(posedge iClock);
        issue(2'b00, 16'h8000, 5'd15);
        expectDone("after_reset", 16'h0001, 17, startCyc);

        // Randomised operations with occasional ignored mid-operation requests.
        for (int k = 0; k < 40; k++) begin
            rop  = 2'($urandom);
            ropd = 16'($urandom);
            ramt = 5'($urandom);
            if (k % 5 == 0) ramt = 5'($urandom_range(0, 2));
            issue(rop, ropd, ramt);
            sc = startCyc;
            if (ramt > 5'd1 && $urandom_range(0, 1) == 1) begin
                issue(2'($urandom), 16'($urandom), 5'($urandom));
            end
            expectDone("rand", refResult(rop, ropd, int'(ramt)), (ramt == 5'd0) ? 1 : int'(ramt) + 2, sc);
            repeat ($urandom_range(0, 2)) @(posedge iClock);
        end

        repeat (3) @(posedge iClock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
